// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: default widths, FSM states, FIFO entry.
// No logic; imported by the fetch interface, FIFO and top.
package fetch_pkg;

    localparam int IW_DEF = 26;
    localparam int AW_DEF = 17;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [IW_DEF-1:0] instr;
        logic [AW_DEF-1:0] addr;
    } fifo_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Memory request/ack bus, instruction valid/ready bus and redirect inputs of the fetch stage.
// master = fetch unit, slave = memory plus control matrix.
interface instruction_fetch_if
    import fetch_pkg::*;
#(
    parameter int IW = IW_DEF,
    parameter int AW = AW_DEF
);

    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [IW-1:0] mem_data;

    logic [IW-1:0] instruction;
    logic [AW-1:0] instruction_addr;
    logic          instruction_valid;
    logic          instruction_ready;

    logic          redirect;
    logic [AW-1:0] redirect_target;

    modport master (
        output mem_req, mem_addr, instruction, instruction_addr, instruction_valid,
        input  mem_ack, mem_data, instruction_ready, redirect, redirect_target
    );

    modport slave (
        input  mem_req, mem_addr, instruction, instruction_addr, instruction_valid,
        output mem_ack, mem_data, instruction_ready, redirect, redirect_target
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {instr, addr} entries; head visible combinationally, one-cycle write.
// Push on full is accepted only when a pop frees the slot the same cycle; flush beats push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fifo_entry_t              pushEntry,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output fifo_entry_t              head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fifo_entry_t   storage [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic          doPush;
    logic          doPop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign head   = storage[rdPtr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) storage[wrPtr] <= pushEntry;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one outstanding memory request at a time, buffers words for the control matrix.
// Request one cycle after reset/redirect settles, word visible one cycle after ack; stops requesting while the FIFO is full.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int              IW         = IW_DEF,
    parameter int              AW         = AW_DEF,
    parameter int              DEPTH      = 4,
    parameter logic [AW-1:0]   RESET_ADDR = '0
)
(
    input  logic               clock,
    input  logic               reset,
    instruction_fetch_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state;
    fetch_state_t  stateNext;
    logic [AW-1:0] fetchPc;
    logic [AW-1:0] fetchPcNext;
    logic [AW-1:0] memAddr;
    logic [AW-1:0] memAddrNext;

    logic          push;
    logic          pop;
    logic          flush;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [CW-1:0] countNext;
    fifo_entry_t   head;
    fifo_entry_t   pushEntry;

    assign pushEntry.instr = bus.mem_data;
    assign pushEntry.addr  = memAddr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            fetchPc <= RESET_ADDR;
            memAddr <= '0;
        end else begin
            state   <= stateNext;
            fetchPc <= fetchPcNext;
            memAddr <= memAddrNext;
        end
    end

    always_comb begin
        stateNext   = state;
        fetchPcNext = fetchPc;
        memAddrNext = memAddr;
        push        = 1'b0;
        flush       = bus.redirect;
        // A handshake coinciding with a redirect is not a consumption.
        pop         = !empty && bus.instruction_ready && !bus.redirect;
        countNext   = count - CW'(pop);

        case (state)
            IDLE: begin
                if (bus.redirect) begin
                    fetchPcNext = bus.redirect_target;
                end else if (!full) begin
                    memAddrNext = fetchPc;
                    stateNext   = REQ;
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    fetchPcNext = bus.redirect_target;
                    stateNext   = bus.mem_ack ? IDLE : DISCARD;
                end else if (bus.mem_ack) begin
                    push        = 1'b1;
                    fetchPcNext = fetchPc + 1'b1;
                    countNext   = count + CW'(1) - CW'(pop);
                    if (countNext < CW'(DEPTH)) begin
                        memAddrNext = fetchPc + 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            DISCARD: begin
                // Request stays up until the stale word is acked and dropped.
                if (bus.redirect) fetchPcNext = bus.redirect_target;
                if (bus.mem_ack)  stateNext   = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .pushEntry (pushEntry),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head      (head)
    );

    assign bus.mem_req           = (state != IDLE);
    assign bus.mem_addr          = memAddr;
    assign bus.instruction_valid = !empty;
    assign bus.instruction       = empty ? '0 : IW'(head.instr);
    assign bus.instruction_addr  = empty ? '0 : AW'(head.addr);

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomised bench for instruction_fetch against a queue-based reference model,
// plus a second instance reset near the top of the address space.
module tb_instruction_fetch;
    import fetch_pkg::*;

    localparam int            IW      = 26;
    localparam int            AW      = 17;
    localparam int            DEPTH   = 4;
    localparam logic [AW-1:0] WRAP_RA = 17'h1FFFE;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    instruction_fetch_if #(.IW(IW), .AW(AW)) bus ();
    instruction_fetch_if #(.IW(IW), .AW(AW)) busW ();

    instruction_fetch #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .RESET_ADDR(17'h00000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    instruction_fetch #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .RESET_ADDR(WRAP_RA)) dutWrap (
        .clock (clock),
        .reset (reset),
        .bus   (busW)
    );

    int    assertCount = 0;
    int    failCount   = 0;
    string phase       = "init";

    // Reference model: what is outstanding, where, and the words queued for the consumer.
    bit            mBusy;
    bit            mDrop;
    logic [AW-1:0] mReqAddr;
    logic [AW-1:0] mPc;
    fifo_entry_t   mQ[$];

    function automatic logic [IW-1:0] memWord(input logic [AW-1:0] a);
        logic [31:0] h;
        h = (32'(a) * 32'h9E3779B1) ^ 32'h01234567;
        return IW'(h >> 3);
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s [%s] got 0x%0h expected 0x%0h at %0t", tag, phase, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mBusy    = 1'b0;
        mDrop    = 1'b0;
        mReqAddr = '0;
        mPc      = '0;
        mQ.delete();
    endtask

    task automatic modelStep(input logic ack, input logic rdy, input logic redir, input logic [AW-1:0] tgt);
        int          sizeBefore;
        bit          popped;
        fifo_entry_t e;
        sizeBefore = mQ.size();
        popped     = (sizeBefore != 0) && rdy && !redir;
        if (popped) void'(mQ.pop_front());
        if (redir) begin
            mQ.delete();
            mPc = tgt;
            if (mBusy) begin
                if (ack) begin
                    mBusy = 1'b0;
                    mDrop = 1'b0;
                end else begin
                    mDrop = 1'b1;
                end
            end
        end else if (!mBusy) begin
            if (sizeBefore < DEPTH) begin
                mBusy    = 1'b1;
                mReqAddr = mPc;
            end
        end else if (mDrop) begin
            if (ack) begin
                mBusy = 1'b0;
                mDrop = 1'b0;
            end
        end else if (ack) begin
            e.instr = memWord(mReqAddr);
            e.addr  = mReqAddr;
            mQ.push_back(e);
            mPc = mPc + 17'd1;
            if (mQ.size() < DEPTH) mReqAddr = mPc;
            else                   mBusy    = 1'b0;
        end
    endtask

    task automatic checkOutputs();
        checkValue("mem_req",           32'(bus.mem_req),           32'(mBusy));
        checkValue("mem_addr",          32'(bus.mem_addr),          32'(mReqAddr));
        checkValue("instruction_valid", 32'(bus.instruction_valid), 32'(mQ.size() != 0));
        checkValue("instruction",       32'(bus.instruction),       (mQ.size() != 0) ? 32'(mQ[0].instr) : 32'd0);
        checkValue("instruction_addr",  32'(bus.instruction_addr),  (mQ.size() != 0) ? 32'(mQ[0].addr)  : 32'd0);
    endtask

    // Called just after a falling edge: check, drive, advance one rising edge, land on the next falling edge.
    task automatic cycle(input logic ack, input logic rdy, input logic redir, input logic [AW-1:0] tgt);
        checkOutputs();
        bus.mem_ack           = ack;
        bus.mem_data          = memWord(bus.mem_addr);
        bus.instruction_ready = rdy;
        bus.redirect          = redir;
        bus.redirect_target   = tgt;
        busW.mem_data         = memWord(busW.mem_addr);
        @(posedge clock);
        modelStep(ack, rdy, redir, tgt);
        @(negedge clock);
    endtask

    initial begin
        reset                  = 1'b1;
        bus.mem_ack            = 1'b0;
        bus.mem_data           = '0;
        bus.instruction_ready  = 1'b0;
        bus.redirect           = 1'b0;
        bus.redirect_target    = '0;
        busW.mem_ack           = 1'b1;
        busW.mem_data          = '0;
        busW.instruction_ready = 1'b1;
        busW.redirect          = 1'b0;
        busW.redirect_target   = '0;
        modelReset();

        repeat (3) @(negedge clock);
        phase = "reset";
        checkOutputs();
        checkValue("w_mem_req_rst",  32'(busW.mem_req),           32'd0);
        checkValue("w_valid_rst",    32'(busW.instruction_valid), 32'd0);
        checkValue("w_mem_addr_rst", 32'(busW.mem_addr),          32'd0);
        reset = 1'b0;

        // Free-running acks with an always-ready consumer; the wrap instance walks across 0x1FFFF.
        phase = "stream";
        for (int k = 1; k <= 10; k++) begin
            cycle(1'b1, 1'b1, 1'b0, '0);
            if (k <= 5) begin
                logic [AW-1:0] ea;
                logic [AW-1:0] eb;
                ea = WRAP_RA + AW'(k - 1);
                eb = ea - 17'd1;
                checkValue("w_mem_req",  32'(busW.mem_req),           32'd1);
                checkValue("w_mem_addr", 32'(busW.mem_addr),          32'(ea));
                checkValue("w_valid",    32'(busW.instruction_valid), 32'(k >= 2));
                if (k >= 2) begin
                    checkValue("w_instr_addr", 32'(busW.instruction_addr), 32'(eb));
                    checkValue("w_instr",      32'(busW.instruction),      32'(memWord(eb)));
                end
            end
        end

        phase = "backpressure";
        repeat (8) cycle(1'b1, 1'b0, 1'b0, '0);
        checkValue("full_req_low", 32'(bus.mem_req),           32'd0);
        checkValue("full_valid",   32'(bus.instruction_valid), 32'd1);
        cycle(1'b1, 1'b1, 1'b0, '0);
        checkValue("pop_req_still_low", 32'(bus.mem_req), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        checkValue("refetch_after_pop", 32'(bus.mem_req), 32'd1);

        phase = "redirect_wait";
        repeat (6) cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b1, 17'h00100);
        checkValue("discard_req_held", 32'(bus.mem_req),           32'd1);
        checkValue("discard_valid",    32'(bus.instruction_valid), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, '0);
        checkValue("discard_done_req",  32'(bus.mem_req),           32'd0);
        checkValue("discard_done_valid",32'(bus.instruction_valid), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        checkValue("target_req_addr", 32'(bus.mem_addr), 32'h00100);
        cycle(1'b1, 1'b0, 1'b0, '0);
        checkValue("target_word_addr", 32'(bus.instruction_addr), 32'h00100);
        checkValue("target_word",      32'(bus.instruction),      32'(memWord(17'h00100)));

        phase = "redirect_ack";
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b1, 17'h00ABC);
        checkValue("flush_valid", 32'(bus.instruction_valid), 32'd0);
        checkValue("flush_req",   32'(bus.mem_req),           32'd0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        checkValue("redir_ack_addr", 32'(bus.mem_addr), 32'h00ABC);

        phase = "random";
        for (int i = 0; i < 2000; i++) begin
            logic [AW-1:0] t;
            t = ($urandom_range(0, 3) == 0) ? (17'h1FFFC + AW'($urandom_range(0, 3))) : AW'($urandom);
            cycle(1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 60),
                  1'($urandom_range(0, 99) < 5), t);
        end

        phase = "random_slow_consumer";
        for (int i = 0; i < 1000; i++) begin
            cycle(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 20),
                  1'($urandom_range(0, 99) < 2), AW'($urandom));
        end

        phase = "async_reset";
        repeat (6) cycle(1'b1, 1'b1, 1'b0, '0);
        repeat (2) cycle(1'b0, 1'b1, 1'b0, '0);
        checkValue("pre_reset_req", 32'(bus.mem_req), 32'd1);
        #2;
        bus.mem_ack = 1'b1;
        reset       = 1'b1;
        #1;
        modelReset();
        checkOutputs();
        @(negedge clock);
        checkOutputs();
        reset = 1'b0;
        cycle(1'b1, 1'b1, 1'b0, '0);
        checkValue("restart_req",   32'(bus.mem_req),           32'd1);
        checkValue("restart_addr",  32'(bus.mem_addr),          32'd0);
        checkValue("restart_valid", 32'(bus.instruction_valid), 32'd0);
        repeat (6) cycle(1'b1, 1'b1, 1'b0, '0);
        checkOutputs();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
